// File: rtl/rv32i_core_pkg.sv
// Shared core types and constants used by the fetch sequencer and its bench.
package rv32i_core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-side bundle: instruction-memory handshake, decode handoff and redirect input.
interface fetch_redirect_ctrl_if;
    import rv32i_core_pkg::*;

    logic            stall;
    logic            jmp_occur;
    logic [XLEN-1:0] pc_jmpto;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_current;
    logic            flush;
    logic            misalign_err;

    modport master (
        input  stall, jmp_occur, pc_jmpto, imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, instr_valid, instr, pc_current, flush, misalign_err
    );

    modport slave (
        output stall, jmp_occur, pc_jmpto, imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instr, pc_current, flush, misalign_err
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small first-word-fall-through FIFO with synchronous clear; head is visible while count != 0.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rstB,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & (count_reg != FULL);
    assign do_pop  = pop & (count_reg != '0);

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr_reg] <= push_data;
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch sequencer: credit-limited imem requests, PC/instruction buffering, redirect flush and drain.
module fetch_redirect_ctrl
    import rv32i_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int              MAX_OUTSTANDING = 2
) (
    input logic                   clk,
    input logic                   rstB,
    fetch_redirect_ctrl_if.master bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(MAX_OUTSTANDING);

    fetch_state_t    state_reg;
    logic [XLEN-1:0] fpc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   drop_cnt_reg;
    logic            jmp_prev_reg;
    logic            flush_reg;
    logic            misalign_reg;

    logic            redirect;
    logic            misaligned;
    logic            credit_ok;
    logic            req;
    logic            grant;
    logic            rsp;
    logic            accept_rsp;
    logic            deliver;
    logic            instr_valid;
    logic [CW-1:0]   drop_next;
    logic [CW-1:0]   pc_count;
    logic [CW-1:0]   buffered;
    logic [XLEN-1:0] pc_head;
    logic [2*XLEN-1:0] instr_head;

    // Only the rising edge of jmp_occur counts; the branch unit holds it for two cycles.
    assign redirect   = bus.jmp_occur & ~jmp_prev_reg & ((state_reg == RUN) | (state_reg == DRAIN));
    assign misaligned = bus.pc_jmpto[1:0] != 2'b00;
    assign credit_ok  = ({1'b0, outstanding_reg} + {1'b0, buffered}) < CREDITS;
    assign req        = (state_reg == RUN) & ~redirect & credit_ok;
    assign grant      = req & bus.imem_gnt;
    assign rsp        = bus.imem_rvalid & (outstanding_reg != '0);
    assign accept_rsp = rsp & (pc_count != '0) & (state_reg == RUN) & ~redirect;
    assign drop_next  = outstanding_reg - CW'(rsp);
    assign instr_valid = buffered != '0;
    assign deliver    = instr_valid & ~bus.stall;

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
        .clk       (clk),
        .rstB      (rstB),
        .clr       (redirect),
        .push      (grant),
        .push_data (fpc_reg),
        .pop       (accept_rsp),
        .head      (pc_head),
        .count     (pc_count)
    );

    fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(MAX_OUTSTANDING)) u_instr_fifo (
        .clk       (clk),
        .rstB      (rstB),
        .clr       (redirect),
        .push      (accept_rsp),
        .push_data ({pc_head, bus.imem_rdata}),
        .pop       (deliver),
        .head      (instr_head),
        .count     (buffered)
    );

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            state_reg       <= IDLE;
            fpc_reg         <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            jmp_prev_reg    <= 1'b0;
            flush_reg       <= 1'b0;
            misalign_reg    <= 1'b0;
        end else begin
            jmp_prev_reg <= bus.jmp_occur;
            flush_reg    <= redirect;
            if (redirect) begin
                // Everything still owed by memory is discarded, including a coincident response.
                outstanding_reg <= drop_next;
                drop_cnt_reg    <= drop_next;
                if (misaligned) begin
                    state_reg    <= HALT;
                    misalign_reg <= 1'b1;
                end else begin
                    fpc_reg   <= bus.pc_jmpto;
                    state_reg <= (drop_next != '0) ? DRAIN : RUN;
                end
            end else begin
                case (state_reg)
                    IDLE: state_reg <= RUN;
                    RUN: begin
                        if (grant) fpc_reg <= fpc_reg + PC_STEP;
                        outstanding_reg <= outstanding_reg + CW'(grant) - CW'(rsp);
                    end
                    DRAIN: begin
                        if (rsp) begin
                            outstanding_reg <= outstanding_reg - CW'(1);
                            drop_cnt_reg    <= drop_cnt_reg - CW'(1);
                            if (drop_cnt_reg == CW'(1)) state_reg <= RUN;
                        end
                    end
                    HALT: ;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.imem_req     = req;
    assign bus.imem_addr    = fpc_reg;
    assign bus.instr_valid  = instr_valid;
    assign bus.instr        = instr_valid ? instr_head[XLEN-1:0] : '0;
    assign bus.pc_current   = instr_valid ? instr_head[2*XLEN-1:XLEN] : '0;
    assign bus.flush        = flush_reg;
    assign bus.misalign_err = misalign_reg;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Randomised bench for fetch_redirect_ctrl: a queue-based memory/decode model predicts every cycle.
module tb_fetch_redirect_ctrl;
    import rv32i_core_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rstB = 1'b0;

    fetch_redirect_ctrl_if bus ();

    fetch_redirect_ctrl #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAXO)) dut (
        .clk  (clk),
        .rstB (rstB),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; int due; } mem_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;

    // Reference model: what memory still owes, what decode should see, and the redirect rules.
    mem_t        mem_q[$];
    ins_t        buf_q[$];
    logic [31:0] m_fpc;
    int          m_drop;
    bit          m_halt, m_merr, m_flush, m_jlast;
    int          m_since;
    int          cyc;

    int          gnt_pct, lat_lo, lat_hi, stall_pct;
    bit          jmp_v;
    logic [31:0] tgt_v;

    logic [31:0] delivered[$];
    logic [31:0] grants[$];
    int          flush_seen, rv_seen;

    bit          obs_req, obs_valid, obs_flush, obs_merr;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    int vectors = 0;
    int miscompares = 0;

    task automatic model_reset();
        mem_q.delete();
        buf_q.delete();
        m_fpc = RESET_PC; m_drop = 0; m_halt = 0; m_merr = 0;
        m_flush = 0; m_jlast = 0; m_since = 0;
        delivered.delete(); grants.delete();
        flush_seen = 0; rv_seen = 0;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rstB = 1'b0;
        jmp_v = 1'b0; tgt_v = '0;
        bus.stall = 1'b0; bus.jmp_occur = 1'b0; bus.pc_jmpto = '0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        model_reset();
    endtask

    task automatic release_reset(int n);
        repeat (n) @(negedge clk);
        @(posedge clk);
        #1 rstB = 1'b1;
    endtask

    // One clock: drive inputs, sample outputs, compare with the model, then advance the model.
    task automatic step();
        bit rv, gnt, stl, redir, exp_req, exp_valid;
        int lat;
        mem_t ent;
        ins_t ins;
        @(negedge clk);
        rv  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        gnt = $urandom_range(99) < gnt_pct;
        stl = $urandom_range(99) < stall_pct;
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? mem_q[0].data : $urandom();
        bus.stall       = stl;
        bus.jmp_occur   = jmp_v;
        bus.pc_jmpto    = tgt_v;
        #1;
        obs_req = bus.imem_req; obs_addr = bus.imem_addr; obs_valid = bus.instr_valid;
        obs_pc = bus.pc_current; obs_instr = bus.instr;
        obs_flush = bus.flush; obs_merr = bus.misalign_err;

        redir     = jmp_v && !m_jlast && (m_since >= 1) && !m_halt;
        exp_req   = (m_since >= 1) && !m_halt && (m_drop == 0) && !redir &&
                    ((mem_q.size() + buf_q.size()) < MAXO);
        exp_valid = buf_q.size() > 0;

        vectors++;
        if (obs_req !== exp_req) begin
            miscompares++;
            $display("FAIL imem_req cyc=%0d got=%0b exp=%0b", cyc, obs_req, exp_req);
        end
        vectors++;
        if (obs_addr !== m_fpc) begin
            miscompares++;
            $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, m_fpc);
        end
        vectors++;
        if (obs_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL instr_valid cyc=%0d got=%0b exp=%0b", cyc, obs_valid, exp_valid);
        end
        if (exp_valid) begin
            vectors++;
            if (obs_pc !== buf_q[0].pc || obs_instr !== buf_q[0].data) begin
                miscompares++;
                $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                         cyc, obs_pc, obs_instr, buf_q[0].pc, buf_q[0].data);
            end
        end
        vectors++;
        if (obs_flush !== m_flush) begin
            miscompares++;
            $display("FAIL flush cyc=%0d got=%0b exp=%0b", cyc, obs_flush, m_flush);
        end
        vectors++;
        if (obs_merr !== m_merr) begin
            miscompares++;
            $display("FAIL misalign_err cyc=%0d got=%0b exp=%0b", cyc, obs_merr, m_merr);
        end

        flush_seen += int'(obs_flush);
        rv_seen    += int'(rv);
        if (obs_valid && !stl) delivered.push_back(obs_pc);
        if (obs_req && gnt) grants.push_back(obs_addr);

        if (exp_valid && !stl) void'(buf_q.pop_front());
        if (exp_req && gnt) begin
            lat = int'($urandom_range(lat_hi, lat_lo));
            ent.addr = m_fpc;
            ent.data = $urandom();
            ent.due  = cyc + lat;
            if (mem_q.size() > 0 && mem_q[$].due > ent.due) ent.due = mem_q[$].due;
            mem_q.push_back(ent);
            m_fpc += 32'd4;
        end
        if (rv) begin
            ent = mem_q.pop_front();
            if (!m_halt && !redir) begin
                if (m_drop > 0) m_drop--;
                else begin
                    ins.pc = ent.addr; ins.data = ent.data;
                    buf_q.push_back(ins);
                end
            end
        end
        if (redir) begin
            buf_q.delete();
            m_drop = mem_q.size();
            if (tgt_v[1:0] != 2'b00) begin
                m_halt = 1'b1;
                m_merr = 1'b1;
            end else begin
                m_fpc = tgt_v;
            end
        end
        m_flush = redir;
        m_jlast = jmp_v;
        m_since++;
        cyc++;
    endtask

    task automatic test_reset();
        gnt_pct = 100; lat_lo = 1; lat_hi = 1; stall_pct = 0;
        assert_reset();
        #1;
        vectors++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== RESET_PC || bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fetch req=%0b addr=%h valid=%0b exp 0/%h/0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid, RESET_PC);
        end
        vectors++;
        if (bus.instr !== 32'h0 || bus.pc_current !== 32'h0 || bus.flush !== 1'b0 ||
            bus.misalign_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out instr=%h pc=%h flush=%0b merr=%0b exp all 0",
                     bus.instr, bus.pc_current, bus.flush, bus.misalign_err);
        end
        release_reset(3);
        step();
        vectors++;
        if (obs_req !== 1'b0) begin
            miscompares++;
            $display("FAIL first_edge_req got=%0b exp=0", obs_req);
        end
        step();
        vectors++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL second_edge_req got req=%0b addr=%h exp 1/%h", obs_req, obs_addr, RESET_PC);
        end
        repeat (10) step();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (delivered.size() <= i || delivered[i] !== RESET_PC + 32'(4 * i)) begin
                miscompares++;
                $display("FAIL reset_order idx=%0d got=%h exp=%h", i,
                         (delivered.size() > i) ? delivered[i] : 32'hxxxx_xxxx, RESET_PC + 32'(4 * i));
            end
        end
        $display("test_reset done, %0d delivered", delivered.size());
    endtask

    task automatic test_backpressure();
        int g;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1; stall_pct = 100;
        assert_reset();
        release_reset(2);
        g = 0;
        repeat (7) begin
            step();
            g += int'(obs_req);
        end
        vectors++;
        if (g !== 2 || obs_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_grants got=%0d last_req=%0b exp 2/0", g, obs_req);
        end
        delivered.delete();
        stall_pct = 0;
        repeat (6) step();
        vectors++;
        if (delivered.size() < 3 || delivered[0] !== 32'h0 || delivered[1] !== 32'h4 ||
            delivered[2] !== 32'h8) begin
            miscompares++;
            $display("FAIL stall_release got n=%0d first=%h exp 0,4,8", delivered.size(),
                     (delivered.size() > 0) ? delivered[0] : 32'hxxxx_xxxx);
        end
        $display("test_backpressure done, grants under stall=%0d", g);
    endtask

    task automatic test_redirect_inflight();
        int rv_before;
        gnt_pct = 100; lat_lo = 4; lat_hi = 4; stall_pct = 0;
        assert_reset();
        release_reset(2);
        for (int i = 0; i < 20 && mem_q.size() < 2; i++) step();
        vectors++;
        if (mem_q.size() != 2 || !obs_req) begin
            miscompares++;
            $display("FAIL inflight_setup got outstanding=%0d exp 2", mem_q.size());
        end
        flush_seen = 0; rv_seen = 0; delivered.delete(); grants.delete();
        jmp_v = 1'b1; tgt_v = 32'h100;
        step(); step();
        jmp_v = 1'b0;
        for (int i = 0; i < 20 && grants.size() == 0; i++) step();
        rv_before = rv_seen;
        repeat (10) step();
        vectors++;
        if (grants.size() == 0 || grants[0] !== 32'h100 || rv_before !== 2) begin
            miscompares++;
            $display("FAIL drain_then_fetch got first=%h rv_before=%0d exp 00000100/2",
                     (grants.size() > 0) ? grants[0] : 32'hxxxx_xxxx, rv_before);
        end
        vectors++;
        if (flush_seen !== 1 || delivered.size() == 0 || delivered[0] !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_deliver got flushes=%0d first=%h exp 1/00000100", flush_seen,
                     (delivered.size() > 0) ? delivered[0] : 32'hxxxx_xxxx);
        end
        $display("test_redirect_inflight done, flushes=%0d", flush_seen);
    endtask

    task automatic test_coincident();
        gnt_pct = 0; lat_lo = 3; lat_hi = 3; stall_pct = 0;
        assert_reset();
        release_reset(2);
        step(); step();
        gnt_pct = 100;
        step();
        gnt_pct = 0;
        for (int i = 0; i < 10 && !(mem_q.size() > 0 && mem_q[0].due <= cyc); i++) step();
        flush_seen = 0; delivered.delete(); grants.delete();
        jmp_v = 1'b1; tgt_v = 32'h200;
        step();
        gnt_pct = 100;
        step();
        vectors++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL coincident_next_req got req=%0b addr=%h exp 1/00000200", obs_req, obs_addr);
        end
        jmp_v = 1'b0;
        repeat (6) step();
        vectors++;
        if (flush_seen !== 1 || delivered.size() == 0 || delivered[0] !== 32'h200) begin
            miscompares++;
            $display("FAIL coincident_drop got flushes=%0d first=%h exp 1/00000200", flush_seen,
                     (delivered.size() > 0) ? delivered[0] : 32'hxxxx_xxxx);
        end
        $display("test_coincident done, delivered=%0d", delivered.size());
    endtask

    task automatic test_misaligned();
        int r;
        gnt_pct = 100; lat_lo = 2; lat_hi = 2; stall_pct = 0;
        assert_reset();
        release_reset(2);
        repeat (6) step();
        jmp_v = 1'b1; tgt_v = 32'h102;
        step(); step();
        jmp_v = 1'b0;
        r = 0;
        repeat (10) begin
            step();
            r += int'(obs_req) + int'(obs_valid);
        end
        vectors++;
        if (r !== 0 || obs_merr !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_hold got active=%0d merr=%0b exp 0/1", r, obs_merr);
        end
        assert_reset();
        #1;
        vectors++;
        if (bus.misalign_err !== 1'b0 || bus.imem_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL halt_reset got merr=%0b addr=%h exp 0/%h", bus.misalign_err, bus.imem_addr, RESET_PC);
        end
        release_reset(1);
        step(); step();
        vectors++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL halt_resume got req=%0b addr=%h exp 1/%h", obs_req, obs_addr, RESET_PC);
        end
        $display("test_misaligned done");
    endtask

    task automatic test_reset_in_drain();
        gnt_pct = 100; lat_lo = 5; lat_hi = 5; stall_pct = 0;
        assert_reset();
        release_reset(2);
        repeat (3) step();
        jmp_v = 1'b1; tgt_v = 32'h40;
        step(); step();
        vectors++;
        if (dut.state_reg !== DRAIN) begin
            miscompares++;
            $display("FAIL drain_entry got state=%0d exp=%0d", dut.state_reg, DRAIN);
        end
        assert_reset();
        #1;
        vectors++;
        if (dut.state_reg !== IDLE || dut.outstanding_reg !== '0 || dut.drop_cnt_reg !== '0 ||
            bus.imem_req !== 1'b0 || bus.flush !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_reset got state=%0d out=%0d drop=%0d req=%0b flush=%0b exp IDLE/0/0/0/0",
                     dut.state_reg, dut.outstanding_reg, dut.drop_cnt_reg, bus.imem_req, bus.flush);
        end
        release_reset(1);
        repeat (8) step();
        $display("test_reset_in_drain done");
    endtask

    task automatic test_random();
        int hold;
        gnt_pct = 70; lat_lo = 1; lat_hi = 4; stall_pct = 30;
        assert_reset();
        release_reset(2);
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) jmp_v = 1'b0;
            end else if ($urandom_range(99) < 6) begin
                jmp_v = 1'b1;
                tgt_v = 32'($urandom_range(4095, 0)) << 2;
                hold  = 2;
            end
            step();
        end
        jmp_v = 1'b0;
        $display("test_random done, delivered=%0d", delivered.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        jmp_v = 1'b0; tgt_v = '0;
        gnt_pct = 0; lat_lo = 1; lat_hi = 1; stall_pct = 0;
        bus.stall = 1'b0; bus.jmp_occur = 1'b0; bus.pc_jmpto = '0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        model_reset();
        test_reset();
        test_backpressure();
        test_redirect_inflight();
        test_coincident();
        test_misaligned();
        test_reset_in_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
